// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel byte as start, data (LSB first), optional parity, 1/2 stop bits.
// Latency: tx reflects the current state one clk later; first start bit begins after the first tick following accept.
// Backpressure: tx_ready is high only in IDLE; tx_valid held while not ready waits until the current frame completes.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic                 par_en_q, par_en_nxt;
  logic                 par_bit_q, par_bit_nxt;
  logic                 stop2_q, stop2_nxt;
  logic                 second_q, second_nxt;
  logic                 done_nxt;
  logic                 tx_nxt;
  logic                 accept;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid & tx_ready;

  // Next-state, datapath and line-level decode; every bit transition waits for a baud tick.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    cnt_nxt     = cnt_q;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit_q;
    stop2_nxt   = stop2_q;
    second_nxt  = second_q;
    done_nxt    = 1'b0;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: begin
        // A tick coinciding with accept is deliberately not consumed: ARM waits for the next one.
        if (accept) begin
          state_nxt   = ARM;
          shift_nxt   = tx_data;
          par_en_nxt  = parity_en;
          par_bit_nxt = (^tx_data) ^ parity_odd;
          stop2_nxt   = stop2;
          cnt_nxt     = '0;
          second_nxt  = 1'b0;
        end
      end
      ARM: begin
        if (baud_tick) state_nxt = START;
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_tick) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        tx_nxt = shift_q[0];
        if (baud_tick) begin
          if (cnt_q == LAST_BIT) begin
            state_nxt  = par_en_q ? PARITY : STOP;
            second_nxt = 1'b0;
          end else begin
            shift_nxt = shift_q >> 1;
            cnt_nxt   = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        tx_nxt = par_bit_q;
        if (baud_tick) begin
          state_nxt  = STOP;
          second_nxt = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop2_q && !second_q) begin
            second_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered line output; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      second_q  <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_nxt;
      cnt_q     <= cnt_nxt;
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
      stop2_q   <= stop2_nxt;
      second_q  <= second_nxt;
      tx        <= tx_nxt;
      tx_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: tick every 4 clks, frames checked bit by bit and clk by clk.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   tick_cnt = 0;
  logic ready_at_done = 1'b0;

  uart_tx_serializer #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick: one clk high out of every four, changed on the falling edge.
  always @(negedge clk) begin
    if (tick_cnt == 3) begin
      tick_cnt  = 0;
      baud_tick = 1'b1;
    end else begin
      tick_cnt  = tick_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  // Present one byte, hold it for the accepting edge, then scramble all inputs.
  task automatic send_byte(input logic [7:0] d, input logic pen, input logic podd, input logic s2);
    int to;
    to = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && to < 300) begin
      @(negedge clk);
      to++;
    end
    tx_data    = d;
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid   = 1'b0;
    tx_data    = ~d;
    parity_en  = ~pen;
    parity_odd = ~podd;
    stop2      = ~s2;
    n_checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL accept_%02h: ready=%b busy=%b, required ready=0 busy=1", d, tx_ready, tx_busy);
    end
  endtask

  // Wait for a start bit, then require every frame bit to hold its level for exactly 4 clks.
  task automatic capture_frame(input logic [11:0] exp, input int nbits, input string name,
                               output int start_cyc);
    int   to;
    int   done_cnt;
    int   early;
    int   bad_busy;
    logic ok;
    logic bad_val;
    start_cyc = -1;
    to = 0;
    while (tx !== 1'b0 && to < 300) begin
      @(negedge clk);
      to++;
    end
    n_checks++;
    if (tx !== 1'b0) begin
      n_fails++;
      $display("FAIL %s start: tx=%b, required 0 within 300 clks", name, tx);
      return;
    end
    start_cyc = cyc;
    done_cnt  = 0;
    early     = 0;
    bad_busy  = 0;
    for (int i = 0; i < nbits; i++) begin
      ok      = 1'b1;
      bad_val = exp[i];
      for (int j = 0; j < 4; j++) begin
        if (i != 0 || j != 0) @(negedge clk);
        if (tx !== exp[i]) begin
          ok      = 1'b0;
          bad_val = tx;
        end
        if (tx_done === 1'b1) begin
          done_cnt++;
          if (i < nbits - 1) early++;
          ready_at_done = tx_ready;
        end
        if (i < nbits - 1 && tx_busy !== 1'b1) bad_busy++;
      end
      n_checks++;
      if (!ok) begin
        n_fails++;
        $display("FAIL %s bit %0d: tx=%b, required %b for 4 clks", name, i, bad_val, exp[i]);
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 1 || early != 0) begin
      n_fails++;
      $display("FAIL %s done: pulses=%0d early=%0d, required 1 and 0", name, done_cnt, early);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fails++;
      $display("FAIL %s busy: low in %0d samples mid-frame, required 0", name, bad_busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fails++; $display("FAIL reset_tx: %b, required 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: %b, required 1", tx_ready); end
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: %b, required 0", tx_busy); end
    n_checks++;
    if (tx_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: %b, required 0", tx_done); end
    tx_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fails++; $display("FAIL reset_no_accept: busy=%b, required 0", tx_busy); end
  endtask

  task automatic test_basic();
    int s;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    capture_frame({2'b00, 1'b1, 8'hA5, 1'b0}, 10, "basic_a5", s);
  endtask

  task automatic test_parity();
    int s;
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    capture_frame({1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, "par_even_a5", s);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
    capture_frame({1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, "par_odd_a5", s);
    send_byte(8'h07, 1'b1, 1'b0, 1'b0);
    capture_frame({1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "par_even_07", s);
  endtask

  task automatic test_stop2();
    int s;
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    capture_frame({1'b0, 2'b11, 8'h00, 1'b0}, 11, "stop2_00", s);
  endtask

  task automatic test_back_to_back();
    int s1;
    int s2;
    int to;
    to = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && to < 300) begin @(negedge clk); to++; end
    tx_data   = 8'h55;
    parity_en = 1'b0;
    stop2     = 1'b0;
    tx_valid  = 1'b1;
    to = 0;
    @(negedge clk);
    while (tx_ready !== 1'b0 && to < 300) begin @(negedge clk); to++; end
    tx_data       = 8'hAA;
    ready_at_done = 1'b0;
    capture_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, "b2b_55", s1);
    n_checks++;
    if (ready_at_done !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_ready_at_done: %b, required 1", ready_at_done);
    end
    n_checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_second_accept: ready=%b busy=%b, required 0 1", tx_ready, tx_busy);
    end
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    capture_frame({2'b00, 1'b1, 8'hAA, 1'b0}, 10, "b2b_aa", s2);
    n_checks++;
    if (s2 - s1 != 44) begin
      n_fails++;
      $display("FAIL b2b_spacing: %0d clks between start bits, required 44", s2 - s1);
    end
  endtask

  task automatic test_mid_reset();
    int   s;
    int   to;
    logic bad;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    to = 0;
    while (tx !== 1'b0 && to < 300) begin @(negedge clk); to++; end
    repeat (17) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin n_fails++; $display("FAIL midrst_bit3: tx=%b, required 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fails++; $display("FAIL midrst_tx: %b, required 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_flags: ready=%b busy=%b done=%b, required 1 0 0", tx_ready, tx_busy, tx_done);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fails++; $display("FAIL midrst_quiet: tx/done moved after abort, required tx=1 done=0"); end
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    capture_frame({2'b00, 1'b1, 8'h3C, 1'b0}, 10, "midrst_3c", s);
  endtask

  initial begin
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = 8'hFF;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    baud_tick  = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
